// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and slave: FSM state encoding and the
// CPOL/CPHA mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

  localparam int CPOL_IDLE_LOW     = 0;
  localparam int CPOL_IDLE_HIGH    = 1;
  localparam int CPHA_SAMPLE_LEAD  = 0;
  localparam int CPHA_SAMPLE_TRAIL = 1;

  localparam int DIV_W     = 8;
  localparam int SPI_EDGES = 16;

  // True when an spi_clk edge of the given kind is a sampling edge in this mode.
  function automatic logic is_sample_edge(input int cpha, input logic lead);
    return (cpha == CPHA_SAMPLE_LEAD) ? lead : !lead;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for spi_master: one-cycle tick every CLK_DIV clk cycles,
// held at zero while clr is high.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clr && (cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master with configurable mode, bit order and clock divider.
// Define SPI_MASTER_MISO_EN to build the receive path; otherwise rx_data is 0.
module spi_master
  import spi_pkg::*;
#(
  parameter int CPOL     = CPOL_IDLE_LOW,
  parameter int CPHA     = CPHA_SAMPLE_LEAD,
  parameter int LSBFIRST = 1,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold_cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_cs,
  input  logic       spi_miso
);

  localparam logic CPOL_B = 1'(CPOL);

  spi_state_t state;
  logic       tick;
  logic [4:0] edge_cnt;
  logic [7:0] tx_sr;
  logic       hold_q;
  logic       lead_edge;

  // LSBFIRST=1 moves data through bit 7 first, LSBFIRST=0 through bit 0.
  function automatic logic out_bit(input logic [7:0] sr);
    return (LSBFIRST != 0) ? sr[7] : sr[0];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] sr);
    return (LSBFIRST != 0) ? {sr[6:0], 1'b0} : {1'b0, sr[7:1]};
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return (LSBFIRST != 0) ? {sr[6:0], b} : {b, sr[7:1]};
  endfunction

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  // Even edge indices are leading edges (away from the idle level).
  assign lead_edge = ~edge_cnt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= CPOL_B;
      spi_mosi <= 1'b0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      hold_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_clk <= CPOL_B;
          // The done cycle is still IDLE but must not accept a new byte.
          if (start && !done) begin
            state  <= ST_LEAD;
            busy   <= 1'b1;
            spi_cs <= 1'b0;
            hold_q <= hold_cs;
            if (CPHA == CPHA_SAMPLE_LEAD) begin
              spi_mosi <= out_bit(tx_data);
              tx_sr    <= shift_out(tx_data);
            end else begin
              tx_sr <= tx_data;
            end
          end
        end
        ST_LEAD: begin
          if (tick) state <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            spi_clk <= ~spi_clk;
            // The final edge never shifts so mosi holds through TRAIL.
            if (!is_sample_edge(CPHA, lead_edge) && edge_cnt != 5'(SPI_EDGES - 1)) begin
              spi_mosi <= out_bit(tx_sr);
              tx_sr    <= shift_out(tx_sr);
            end
            if (edge_cnt == 5'(SPI_EDGES - 1)) begin
              edge_cnt <= '0;
              state    <= ST_TRAIL;
            end else begin
              edge_cnt <= edge_cnt + 5'd1;
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            spi_cs <= ~hold_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_MISO_EN
  logic       miso_q;
  logic [7:0] rx_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_q  <= 1'b0;
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      miso_q <= spi_miso;
      if (state == ST_XFER && tick && is_sample_edge(CPHA, lead_edge)) begin
        rx_sr <= shift_in(rx_sr, miso_q);
      end
      if (state == ST_TRAIL && tick) begin
        rx_data <= rx_sr;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four differently configured instances, each driven by
// its own stimulus and checked by a behavioural SPI slave and transfer model.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_fin = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark_fin();
    n_fin++;
  endtask

  function automatic logic sbit(input logic [7:0] b, input int k, input int lsb);
    return (lsb != 0) ? b[7-k] : b[k];
  endfunction

  localparam logic [3:0]  CPOL_V = 4'b1010;
  localparam logic [3:0]  CPHA_V = 4'b0110;
  localparam logic [3:0]  LSB_V  = 4'b0101;
  localparam int          DIV_T [4] = '{4, 4, 2, 3};
  localparam logic [31:0] TX_DIR = 32'hC35A3CA5;
  localparam logic [31:0] SL_DIR = 32'h960FFFA5;
`ifdef SPI_MASTER_MISO_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] tx;
    logic [7:0] s;
    logic       hold;
    int         acc;
  } rec_t;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int P_CPOL = int'(CPOL_V[g]);
    localparam int P_CPHA = int'(CPHA_V[g]);
    localparam int P_LSB  = int'(LSB_V[g]);
    localparam int P_DIV  = DIV_T[g];

    logic       rst, start, hold_cs, busy, done, spi_clk, spi_mosi, spi_cs;
    logic       spi_miso = 1'b0;
    logic [7:0] tx_data, rx_data;

    rec_t       q[$];
    rec_t       r;
    int         slv_edges = 0;
    int         slv_idx = 0;
    int         slv_nrx = 0;
    int         n_done = 0;
    logic [7:0] slv_s = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       prev_clk = 1'b0;
    logic       prev_busy = 1'b0;
    logic       cs_bad = 1'b0;
    logic       lead;

    spi_master #(
      .CPOL    (P_CPOL),
      .CPHA    (P_CPHA),
      .LSBFIRST(P_LSB),
      .CLK_DIV (P_DIV)
    ) u_dut (
      .clk     (clk),
      .reset   (rst),
      .start   (start),
      .tx_data (tx_data),
      .hold_cs (hold_cs),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .spi_clk (spi_clk),
      .spi_mosi(spi_mosi),
      .spi_cs  (spi_cs),
      .spi_miso(spi_miso)
    );

    // Slave model and end-of-byte scoreboard.
    always @(negedge clk) begin
      if (rst === 1'b0) begin
        if (busy && !prev_busy) begin
          if (q.size() == 0) begin
            chk($sformatf("i%0d busy_without_start", g), 32'(busy), 32'd0);
          end else begin
            chk($sformatf("i%0d busy_latency", g), cyc - q[0].acc, 32'd1);
            slv_s     = q[0].s;
            slv_edges = 0;
            slv_nrx   = 0;
            slv_rx    = 8'h00;
            cs_bad    = 1'b0;
            slv_idx   = 0;
            if (P_CPHA == 0) begin
              spi_miso = sbit(slv_s, 0, P_LSB);
              slv_idx  = 1;
            end
          end
        end
        if (spi_cs === 1'b0 && spi_clk !== prev_clk) begin
          lead = (prev_clk == 1'(P_CPOL));
          slv_edges++;
          if (lead == (P_CPHA == 0)) begin
            if (slv_nrx < 8) slv_rx[(P_LSB != 0) ? 7 - slv_nrx : slv_nrx] = spi_mosi;
            slv_nrx++;
          end else if (slv_idx < 8) begin
            spi_miso = sbit(slv_s, slv_idx, P_LSB);
            slv_idx++;
          end
        end
        if (q.size() != 0 && cyc > q[0].acc && cyc <= q[0].acc + 18 * P_DIV && spi_cs !== 1'b0)
          cs_bad = 1'b1;
        if (done) begin
          n_done++;
          if (q.size() == 0) begin
            chk($sformatf("i%0d done_without_start", g), 32'(done), 32'd0);
          end else begin
            r = q.pop_front();
            chk($sformatf("i%0d done_latency", g), cyc - r.acc, 32'(18 * P_DIV + 1));
            chk($sformatf("i%0d rx_data", g), 32'(rx_data), 32'(RX_ON ? r.s : 8'h00));
            chk($sformatf("i%0d mosi_byte", g), 32'(slv_rx), 32'(r.tx));
            chk($sformatf("i%0d clk_edges", g), slv_edges, 32'd16);
            chk($sformatf("i%0d cs_low_in_byte", g), 32'(cs_bad), 32'd0);
            chk($sformatf("i%0d cs_after_done", g), 32'(spi_cs), 32'(!r.hold));
            chk($sformatf("i%0d clk_idle", g), 32'(spi_clk), 32'(P_CPOL));
          end
        end
      end
      prev_clk  = spi_clk;
      prev_busy = busy;
    end

    task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 40 * P_DIV + 100) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        chk($sformatf("i%0d wait_timeout", g), q.size(), 32'd0);
        q.delete();
      end
      @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] s, input logic h);
      start   = 1'b1;
      tx_data = tx;
      hold_cs = h;
      q.push_back('{tx: tx, s: s, hold: h, acc: cyc});
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom);
      hold_cs = !h;
      wait_idle();
    endtask

    // start held high: a new byte is accepted every 18*CLK_DIV+2 cycles.
    task automatic burst(input int ncyc);
      int c0;
      c0 = cyc;
      for (int i = 0; i < ncyc; i++) begin
        start   = 1'b1;
        tx_data = 8'($urandom);
        hold_cs = 1'b0;
        if ((cyc - c0) % (18 * P_DIV + 2) == 0)
          q.push_back('{tx: tx_data, s: 8'($urandom), hold: 1'b0, acc: cyc});
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
    endtask

    task automatic reset_mid();
      int n = 0;
      int d0;
      start   = 1'b1;
      tx_data = 8'($urandom);
      hold_cs = 1'b0;
      q.push_back('{tx: tx_data, s: 8'($urandom), hold: 1'b0, acc: cyc});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      while (slv_edges < 5 && n < 20 * P_DIV) begin
        @(negedge clk);
        n++;
      end
      if (slv_edges < 5) chk($sformatf("i%0d edge_wait", g), slv_edges, 32'd5);
      rst = 1'b1;
      #1;
      chk($sformatf("i%0d abort_cs", g), 32'(spi_cs), 32'd1);
      chk($sformatf("i%0d abort_clk", g), 32'(spi_clk), 32'(P_CPOL));
      chk($sformatf("i%0d abort_busy", g), 32'(busy), 32'd0);
      chk($sformatf("i%0d abort_done", g), 32'(done), 32'd0);
      chk($sformatf("i%0d abort_mosi", g), 32'(spi_mosi), 32'd0);
      chk($sformatf("i%0d abort_rx", g), 32'(rx_data), 32'd0);
      q.delete();
      d0 = n_done;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20 * P_DIV) @(negedge clk);
      chk($sformatf("i%0d no_done_after_abort", g), n_done - d0, 32'd0);
    endtask

    initial begin
      rst     = 1'b1;
      start   = 1'b0;
      tx_data = 8'h00;
      hold_cs = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("i%0d rst_cs", g), 32'(spi_cs), 32'd1);
      chk($sformatf("i%0d rst_clk", g), 32'(spi_clk), 32'(P_CPOL));
      chk($sformatf("i%0d rst_mosi", g), 32'(spi_mosi), 32'd0);
      chk($sformatf("i%0d rst_busy", g), 32'(busy), 32'd0);
      chk($sformatf("i%0d rst_done", g), 32'(done), 32'd0);
      chk($sformatf("i%0d rst_rx", g), 32'(rx_data), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      xfer(TX_DIR[8*g +: 8], SL_DIR[8*g +: 8], 1'b0);

      xfer(8'($urandom), 8'($urandom), 1'b1);
      chk($sformatf("i%0d cs_held_between", g), 32'(spi_cs), 32'd0);
      xfer(8'($urandom), 8'($urandom), 1'b0);

      burst(200);

      reset_mid();
      xfer(8'($urandom), 8'($urandom), 1'b0);

      for (int i = 0; i < 10; i++)
        xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      xfer(8'($urandom), 8'($urandom), 1'b0);

      mark_fin();
    end
  end

  initial begin
    int n;
    n = 0;
    while (n_fin < 4 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n_fin < 4) chk("global_timeout", n_fin, 32'd4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CPOL, default 0, idle level of spi_clk.
REQ-002 Parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-003 Parameter LSBFIRST, default 1, bit order: 1 = tx_data[7] first and first received bit lands in rx_data[7]; 0 = tx_data[0] first and first received bit lands in rx_data[0].
REQ-004 Parameter CLK_DIV, default 4, clk cycles per spi_clk half-period, legal range 2..255.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request one byte transfer, accepted only in IDLE.
REQ-008 tx_data  input  8  byte to send, sampled in the accepting cycle.
REQ-009 hold_cs  input  1  sampled with start; 1 = keep spi_cs asserted after this byte.
REQ-010 busy  output  1  high from the cycle after acceptance until done.
REQ-011 done  output  1  one-cycle pulse at end of byte.
REQ-012 rx_data  output  8  byte received on spi_miso, valid from done, held until next done.
REQ-013 spi_clk / spi_mosi / spi_cs  output  1 each  SPI bus, spi_cs active-low.
REQ-014 spi_miso  input  1  SPI data from slave, registered once before use.

Function
REQ-015 FSM states IDLE, LEAD, XFER, TRAIL; each LEAD/TRAIL lasts CLK_DIV cycles; XFER lasts 16*CLK_DIV cycles.
REQ-016 IDLE: spi_clk = CPOL, busy = 0; start=1 latches tx_data/hold_cs into shift register, goes LEAD.
REQ-017 LEAD: spi_cs = 0; CPHA=0 drives first bit on spi_mosi at LEAD entry.
REQ-018 XFER: spi_clk toggles every CLK_DIV cycles, 16 edges total, ending at CPOL.
REQ-019 Sample edges register spi_miso into rx shift register; shift edges advance spi_mosi to next bit; CPHA=1 drives first bit on first leading edge.
REQ-020 TRAIL: spi_clk = CPOL, spi_mosi held; on exit rx_data updates, done pulses, FSM returns to IDLE.
REQ-021 done asserted exactly 18*CLK_DIV+1 clk cycles after the start-accept cycle.
REQ-022 spi_cs returns high in IDLE unless latched hold_cs = 1; then stays low until a byte with hold_cs = 0 completes.
REQ-023 start while busy ignored, no queueing; start in the done cycle ignored, accepted next cycle.
REQ-024 Changes of tx_data/hold_cs after acceptance have no effect on the running byte.
REQ-025 Divider counter wraps to 0 at CLK_DIV-1; edge counter 5 bits, counts 0..15.

Reset
REQ-026 Reset (any time, mid-byte included) forces IDLE, spi_cs = 1, spi_clk = CPOL, spi_mosi = 0, busy = 0, done = 0, rx_data = 0, counters 0; no done for an aborted byte.

Configuration
REQ-027 Macro SPI_MASTER_MISO_EN defined: receive path per REQ-012/019 built.
REQ-028 SPI_MASTER_MISO_EN undefined: no rx shift register or miso register, spi_miso ignored, rx_data constant 0, transmit timing unchanged.

Structure
REQ-029 Shared package spi_pkg holds FSM state encoding and CPOL/CPHA mode constants, shared with the SPI slave.
REQ-030 One sub-module spi_clk_div: CLK_DIV counter producing a one-cycle half-period tick, cleared on FSM leaving IDLE.

Verification
REQ-031 CPOL=0, CPHA=0, LSBFIRST=1, CLK_DIV=4, start with tx_data=0xA5, miso loopback -> mosi bits 1,0,1,0,0,1,0,1 on rising edges, done at cycle 73, rx_data=0xA5.
REQ-032 CPOL=1, CPHA=1, LSBFIRST=0, tx_data=0x3C, miso tied 1 -> mosi 0,0,1,1,1,1,0,0 sampled on rising edges, spi_clk idles high, rx_data=0xFF.
REQ-033 Two starts with hold_cs=1 then 0 -> spi_cs low continuously across both bytes, high after second done.
REQ-034 start held high for 200 cycles, CLK_DIV=2 -> exactly one byte per 38 cycles, second acceptance in the cycle after done, no pulse in the done cycle.
REQ-035 reset asserted after 5th spi_clk edge -> immediately spi_cs=1, spi_clk=CPOL, busy=0, no done; next start completes normally.
REQ-036 Build without SPI_MASTER_MISO_EN, miso toggling -> rx_data stays 0x00, mosi/clk waveform identical to REQ-031.
